charge_dispense_ctrl: RTL and testbench

//  Sequences change return for the vending FSM: on a charge start pulse, takes the

---
 rtl/charge_dispense_ctrl_if.sv | 36 +++
 rtl/charge_dispense_ctrl.sv | 136 +++++++++++++
 tb/tb_charge_dispense_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/charge_dispense_ctrl_if.sv
// Purpose : signal bundle between the vending FSM, the change dispenser and the hopper driver.
// Ports   : master = FSM/hopper side (drives charge_st, charge_amt, hopper_ack);
//           slave  = dispenser (drives busy, eject_req, eject_den, remain, done, err[, coin_cnt]).
// Option  : coin_cnt exists only when CHARGE_COIN_CNT_EN is defined.
interface charge_dispense_ctrl_if #(
    parameter int AMT_W = 11
);
    logic             charge_st;
    logic [AMT_W-1:0] charge_amt;
    logic             hopper_ack;
    logic             busy;
    logic             eject_req;
    logic [1:0]       eject_den;
    logic [AMT_W-1:0] remain;
    logic             done;
    logic             err;
`ifdef CHARGE_COIN_CNT_EN
    logic [7:0]       coin_cnt;
`endif

    modport master (
        output charge_st, charge_amt, hopper_ack,
        input  busy, eject_req, eject_den, remain, done, err
`ifdef CHARGE_COIN_CNT_EN
        , input coin_cnt
`endif
    );

    modport slave (
        input  charge_st, charge_amt, hopper_ack,
        output busy, eject_req, eject_den, remain, done, err
`ifdef CHARGE_COIN_CNT_EN
        , output coin_cnt
`endif
    );
endinterface

// File: rtl/charge_dispense_ctrl.sv
// Purpose : pays out change one coin at a time, largest denomination first, via a req/ack hopper handshake.
// Latency : start -> busy next cycle, first eject_req one cycle later; GAP_CYCLES+1 idle cycles between coins.
// Backpr. : each coin waits for hopper_ack up to ACK_TIMEOUT cycles, then aborts with an err pulse.
// Ports   : clk, rst_n (synchronous, active-low) plus the slave side of charge_dispense_ctrl_if:
//           in charge_st/charge_amt/hopper_ack; out busy/eject_req/eject_den/remain/done/err.
// Option  : CHARGE_COIN_CNT_EN adds coin_cnt (coins ejected in the current/last transaction).
module charge_dispense_ctrl #(
    parameter int AMT_W       = 11,
    parameter int AMT_MAX     = 2000,
    parameter int ACK_TIMEOUT = 1000,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    charge_dispense_ctrl_if.slave  bus
);
    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AMT_W-1:0] AMT_CAP = AMT_W'(AMT_MAX);

    typedef enum logic [2:0] {IDLE, SELECT, REQ, GAP, DONE, ERR} state_t;

    state_t           state, state_nxt;
    logic [AMT_W-1:0] remain, remain_nxt;
    logic [1:0]       den, den_nxt;
    logic             req, req_nxt;
    logic             busy, busy_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;

    // Coin values in 0.5-yuan units: 10r, 5r, 1r, 0.5r.
    function automatic logic [AMT_W-1:0] den_val(input logic [1:0] d);
        case (d)
            2'd0:    den_val = AMT_W'(20);
            2'd1:    den_val = AMT_W'(10);
            2'd2:    den_val = AMT_W'(2);
            default: den_val = AMT_W'(1);
        endcase
    endfunction

    function automatic logic [1:0] pick_den(input logic [AMT_W-1:0] amt);
        if (amt >= AMT_W'(20))      pick_den = 2'd0;
        else if (amt >= AMT_W'(10)) pick_den = 2'd1;
        else if (amt >= AMT_W'(2))  pick_den = 2'd2;
        else                        pick_den = 2'd3;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            remain  <= '0;
            den     <= '0;
            req     <= 1'b0;
            busy    <= 1'b0;
            tmo_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            remain  <= remain_nxt;
            den     <= den_nxt;
            req     <= req_nxt;
            busy    <= busy_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        remain_nxt  = remain;
        den_nxt     = den;
        req_nxt     = req;
        busy_nxt    = busy;
        tmo_cnt_nxt = tmo_cnt;
        gap_cnt_nxt = gap_cnt;
        unique case (state)
            IDLE: begin
                if (bus.charge_st) begin
                    remain_nxt = (bus.charge_amt > AMT_CAP) ? AMT_CAP : bus.charge_amt;
                    busy_nxt   = 1'b1;
                    state_nxt  = SELECT;
                end
            end
            SELECT: begin
                if (remain == '0) begin
                    state_nxt = DONE;
                end else begin
                    den_nxt     = pick_den(remain);
                    req_nxt     = 1'b1;
                    tmo_cnt_nxt = '0;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                // An ack on the final timeout cycle still counts as a paid coin.
                if (bus.hopper_ack) begin
                    remain_nxt  = remain - den_val(den);
                    req_nxt     = 1'b0;
                    gap_cnt_nxt = '0;
                    state_nxt   = (GAP_CYCLES == 0) ? SELECT : GAP;
                end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
                    req_nxt   = 1'b0;
                    state_nxt = ERR;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = SELECT;
                else                                   gap_cnt_nxt = gap_cnt + GAP_W'(1);
            end
            DONE, ERR: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy      = busy;
    assign bus.eject_req = req;
    assign bus.eject_den = den;
    assign bus.remain    = remain;
    assign bus.done      = (state == DONE);
    assign bus.err       = (state == ERR);

`ifdef CHARGE_COIN_CNT_EN
    logic [7:0] coin_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n)                                              coin_cnt <= '0;
        else if (state == IDLE && bus.charge_st)                 coin_cnt <= '0;
        else if (state == REQ && bus.hopper_ack && coin_cnt != 8'hFF) coin_cnt <= coin_cnt + 8'd1;
    end
    assign bus.coin_cnt = coin_cnt;
`endif
endmodule

// File: tb/tb_charge_dispense_ctrl.sv
// Bench for charge_dispense_ctrl: directed scenarios plus random amounts, checked
// against a greedy coin-plan model and the handshake timing rules.
module tb_charge_dispense_ctrl;
    localparam int AMT_W       = 11;
    localparam int AMT_MAX     = 2000;
    localparam int ACK_TIMEOUT = 1000;
    localparam int GAP_CYCLES  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    charge_dispense_ctrl_if #(.AMT_W(AMT_W)) bus ();

    charge_dispense_ctrl #(
        .AMT_W(AMT_W), .AMT_MAX(AMT_MAX), .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int val[4] = '{20, 10, 2, 1};
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Greedy payout plan: list of denominations for a (clamped) amount.
    function automatic void plan(input int rem);
        exp_q.delete();
        for (int d = 0; d < 4; d++) begin
            while (rem >= val[d]) begin
                exp_q.push_back(d);
                rem -= val[d];
            end
        end
    endfunction

    task automatic wait_evt(output int n);
        n = 0;
        while (!(bus.eject_req === 1'b1 || bus.done === 1'b1) && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic run_txn(input int amt, input bit poke_busy, input bit poke_done);
        int rem;
        int w;
        int d;
        rem = (amt > AMT_MAX) ? AMT_MAX : amt;
        plan(rem);
        bus.charge_amt = AMT_W'(amt);
        bus.charge_st  = 1'b1;
        tick();
        bus.charge_st  = 1'b0;
        check("busy_rise", bus.busy, 1);
        check("req_low_at_n1", bus.eject_req, 0);
        check("remain_load", bus.remain, rem);
        wait_evt(w);
        check("first_latency", w, 1);
        foreach (exp_q[i]) begin
            check("req_on", bus.eject_req, 1);
            check("den", bus.eject_den, exp_q[i]);
            d = $urandom_range(0, 3);
            repeat (d) tick();
            check("den_stable", bus.eject_den, exp_q[i]);
            check("req_held", bus.eject_req, 1);
            bus.hopper_ack = 1'b1;
            tick();
            rem -= val[exp_q[i]];
            check("remain_step", bus.remain, rem);
            check("req_drop", bus.eject_req, 0);
            // Stray ack and a second start during the gap must both be ignored.
            bus.hopper_ack = 1'($urandom_range(0, 1));
            if (poke_busy && i == 0) begin
                bus.charge_amt = AMT_W'(5);
                bus.charge_st  = 1'b1;
            end
            tick();
            bus.hopper_ack = 1'b0;
            bus.charge_st  = 1'b0;
            wait_evt(w);
            check("gap_len", w + 1, GAP_CYCLES + 1);
        end
        check("done_pulse", bus.done, 1);
        check("done_remain", bus.remain, 0);
        check("done_busy", bus.busy, 1);
`ifdef CHARGE_COIN_CNT_EN
        check("coin_cnt", bus.coin_cnt, (exp_q.size() > 255) ? 255 : exp_q.size());
`endif
        if (poke_done) begin
            bus.charge_amt = AMT_W'(9);
            bus.charge_st  = 1'b1;
        end
        tick();
        bus.charge_st = 1'b0;
        check("done_drop", bus.done, 0);
        check("busy_drop", bus.busy, 0);
        check("idle_remain", bus.remain, 0);
        tick();
        check("idle_busy", bus.busy, 0);
        check("idle_req", bus.eject_req, 0);
    endtask

    initial begin
        int w;
        int n;
        rst_n          = 1'b0;
        bus.charge_st  = 1'b0;
        bus.charge_amt = '0;
        bus.hopper_ack = 1'b0;
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_req", bus.eject_req, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_den", bus.eject_den, 0);
        check("rst_remain", bus.remain, 0);
        rst_n = 1'b1;
        tick();

        run_txn(37, 1'b1, 1'b0);     // 20,10,2,2,2,1 with an ignored start mid-way
        run_txn(0, 1'b0, 1'b1);      // immediate done, start during done ignored
        run_txn(2047, 1'b0, 1'b0);   // clamped to 2000 -> 100 big coins

        // Ack never comes: request held for exactly ACK_TIMEOUT cycles, then err.
        bus.charge_amt = AMT_W'(20);
        bus.charge_st  = 1'b1;
        tick();
        bus.charge_st  = 1'b0;
        wait_evt(w);
        check("tmo_first_latency", w, 1);
        check("tmo_den", bus.eject_den, 0);
        n = 0;
        while (bus.eject_req === 1'b1 && n < 1200) begin
            tick();
            n++;
        end
        check("tmo_req_cycles", n, ACK_TIMEOUT);
        check("tmo_err_pulse", bus.err, 1);
        check("tmo_done_low", bus.done, 0);
        check("tmo_remain", bus.remain, 20);
        tick();
        check("tmo_err_drop", bus.err, 0);
        check("tmo_busy_drop", bus.busy, 0);
        check("tmo_remain_hold", bus.remain, 20);

        // Reset in the middle of a request.
        bus.charge_amt = AMT_W'(37);
        bus.charge_st  = 1'b1;
        tick();
        bus.charge_st  = 1'b0;
        wait_evt(w);
        check("mid_req_on", bus.eject_req, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_req", bus.eject_req, 0);
        check("mid_rst_den", bus.eject_den, 0);
        check("mid_rst_remain", bus.remain, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_err", bus.err, 0);
        rst_n = 1'b1;
        bus.hopper_ack = 1'b1;
        repeat (3) tick();
        bus.hopper_ack = 1'b0;
        check("post_rst_req", bus.eject_req, 0);
        check("post_rst_busy", bus.busy, 0);
        run_txn(3, 1'b0, 1'b0);      // 1r then 0.5r

        for (int t = 0; t < 8; t++) begin
            int amt;
            amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 120);
            run_txn(amt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
